// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master and the SPI receive endpoint.
//   spi_state_e - receiver FSM states (IDLE, SHIFT)
//   SPI_DATA_W  - default word width
//   SPI_CPOL/SPI_CPHA - link mode 0: SCLK idles low, data sampled on rising SCLK
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int unsigned SPI_DATA_W = 8;
  localparam bit          SPI_CPOL   = 1'b0;
  localparam bit          SPI_CPHA   = 1'b0;

endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins plus the receive-side valid/ready handshake.
//   sclk, cs, mosi       - SPI link from the master (cs active low)
//   rx_data, rx_valid    - received word and its valid flag
//   rx_ready             - consumer accept
//   overrun, busy        - status (overrun is a one-cycle pulse)
//   frame_err            - partial-word abort pulse, present only with
//                          SPI_RX_FRAME_ERR_EN defined
// modport slave  : the receiver (spi_slave_rx)
// modport master : the environment (SPI master pins + consumer)
interface spi_slave_rx_if import spi_pkg::*; #(
  parameter int unsigned DATA_W = SPI_DATA_W
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              busy;
`ifdef SPI_RX_FRAME_ERR_EN
  logic              frame_err;
`endif

  modport slave (
    input  sclk, cs, mosi, rx_ready,
    output rx_data, rx_valid, overrun, busy
`ifdef SPI_RX_FRAME_ERR_EN
    , output frame_err
`endif
  );

  modport master (
    output sclk, cs, mosi, rx_ready,
    input  rx_data, rx_valid, overrun, busy
`ifdef SPI_RX_FRAME_ERR_EN
    , input frame_err
`endif
  );
endinterface

// File: rtl/spi_sync_bit.sv
// spi_sync_bit: STAGES-deep flop synchronizer for one asynchronous bit.
//   clk, rst_n - system clock, async active-low reset
//   i_d        - asynchronous input
//   o_q        - synchronized output; every stage resets to RST_VAL
module spi_sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {STAGES{RST_VAL}};
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 receive endpoint, MSB first, oversampled in clk.
//   clk, rst_n - system clock, async active-low reset
//   bus        - spi_slave_rx_if.slave: sclk/cs/mosi in, rx_data/rx_valid
//                out with rx_ready accept, overrun pulse, busy (= !cs_s)
// Optional: SPI_RX_FRAME_ERR_EN adds bus.frame_err, a one-cycle pulse when
// cs rises mid-word. DATA_W must match the interface's DATA_W.
module spi_slave_rx import spi_pkg::*; #(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_rx_if.slave  bus
);
  localparam int unsigned    CW    = $clog2(DATA_W);
  localparam logic [CW-1:0]  LAST  = CW'(DATA_W - 1);
  localparam logic [3:0]     FLUSH = 4'(SYNC_STAGES);

  logic w_sclk_s, w_cs_s, w_mosi_s;

  spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(bus.sclk), .o_q(w_sclk_s));
  spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_d(bus.cs), .o_q(w_cs_s));
  spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_d(bus.mosi), .o_q(w_mosi_s));

  spi_state_e        r_state, w_state_nxt;
  logic [CW-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-2:0] r_shift, w_shift_nxt;
  logic [DATA_W-1:0] r_data, w_word;
  logic              r_valid, r_overrun, r_busy, r_sclk_q, r_cs_hi;
  logic [3:0]        r_flush;
  logic              w_rise, w_done, w_partial;

  assign w_rise = w_sclk_s & ~r_sclk_q;
  assign w_word = {r_shift, w_mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_done        = 1'b0;
    w_partial     = 1'b0;
    case (r_state)
      IDLE: begin
        w_bit_cnt_nxt = '0;
        w_shift_nxt   = '0;
        if (r_cs_hi && !w_cs_s) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_cs_s) begin
          // cs release wins over a coincident SCLK rise
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = '0;
          w_partial     = (r_bit_cnt != '0);
        end else if (w_rise) begin
          w_shift_nxt = w_word[DATA_W-2:0];
          if (r_bit_cnt == LAST) begin
            w_bit_cnt_nxt = '0;
            w_done        = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_cs_hi records a genuine high on cs_s. It stays low until the
  // synchronizer has flushed its reset value, so a frame already in
  // progress when reset is released never looks like a cs fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      r_sclk_q  <= 1'b0;
      r_cs_hi   <= 1'b0;
      r_flush   <= '0;
    end else begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_sclk_q  <= w_sclk_s;
      r_busy    <= ~w_cs_s;
      r_cs_hi   <= (r_flush == FLUSH) & w_cs_s;
      if (r_flush != FLUSH) r_flush <= r_flush + 1'b1;
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_valid || bus.rx_ready) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data  = r_data;
  assign bus.rx_valid = r_valid;
  assign bus.overrun  = r_overrun;
  assign bus.busy     = r_busy;

`ifdef SPI_RX_FRAME_ERR_EN
  logic r_frame_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_err <= 1'b0;
    else        r_frame_err <= (r_state == SHIFT) && w_partial;
  end
  assign bus.frame_err = r_frame_err;
`else
  // partial words are discarded silently; the abort flag has no consumer
  logic w_unused_partial;
  assign w_unused_partial = w_partial;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench for spi_slave_rx. SPI pins and rx_ready
// are driven on the falling clk edge; handshakes and pulses are counted on
// the rising edge. SPI_RX_FRAME_ERR_EN enables the frame_err checks.
module tb_spi_slave_rx;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   ovr_cnt;
  int   fe_cnt;
  logic [7:0] hs_q[$];

  spi_slave_rx_if #(.DATA_W(8)) bus ();

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rx_valid && bus.rx_ready) hs_q.push_back(bus.rx_data);
    if (bus.overrun === 1'b1) ovr_cnt++;
`ifdef SPI_RX_FRAME_ERR_EN
    if (bus.frame_err === 1'b1) fe_cnt++;
`endif
  end

  // one SCLK period of 8 clk; optional rx_ready pulse on the delivery edge
  task automatic send_bit(input logic b, input bit pulse);
    bus.sclk = 1'b0;
    bus.mosi = b;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b1;
    repeat (2) @(negedge clk);
    if (pulse) bus.rx_ready = 1'b1;
    @(negedge clk);
    if (pulse) bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pulse_last);
    for (int i = 7; i >= 0; i--) send_bit(b[i], pulse_last && (i == 0));
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.sclk = 1'b0;
    bus.cs   = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain();
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_valid: got %b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0; bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 || bus.overrun !== 1'b0
        || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b ovr=%b busy=%b want 00 0 0 0",
               bus.rx_data, bus.rx_valid, bus.overrun, bus.busy);
    end
`ifdef SPI_RX_FRAME_ERR_EN
    n_checks++;
    if (bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_frame_err: got %b want 0", bus.frame_err);
    end
`endif
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b want 0 0", bus.busy, bus.rx_valid);
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    int ovr0, fe0, hs0;
    b = 8'hAA; ovr0 = ovr_cnt; fe0 = fe_cnt; hs0 = hs_q.size();
    cs_low();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_frame: got %b want 1", bus.busy);
    end
    for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b0);
    bus.sclk = 1'b0;
    bus.mosi = b[0];
    repeat (4) @(negedge clk);
    bus.sclk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got valid=%b want 0 two edges after sclk rise", bus.rx_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL latency_deliver: got valid=%b data=%h want 1 aa", bus.rx_valid, bus.rx_data);
    end
    @(negedge clk);
    cs_high();
    n_checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hAA || ovr_cnt != ovr0) begin
      n_fail++;
      $display("FAIL single_hold: got valid=%b data=%h ovr=%0d want 1 aa 0",
               bus.rx_valid, bus.rx_data, ovr_cnt - ovr0);
    end
    n_checks++;
    if (fe_cnt != fe0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got frame_err pulses=%0d busy=%b want 0 0", fe_cnt - fe0, bus.busy);
    end
    drain();
    n_checks++;
    if (hs_q.size() != hs0 + 1 || hs_q[hs_q.size()-1] !== 8'hAA) begin
      n_fail++;
      $display("FAIL single_handshake: got count=%0d want 1 of aa", hs_q.size() - hs0);
    end
  endtask

  task automatic test_back_to_back();
    int ovr0, hs0;
    ovr0 = ovr_cnt; hs0 = hs_q.size();
    bus.rx_ready = 1'b1;
    cs_low();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    cs_high();
    bus.rx_ready = 1'b0;
    n_checks++;
    if (hs_q.size() != hs0 + 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d handshakes want 2", hs_q.size() - hs0);
    end else begin
      n_checks++;
      if (hs_q[hs0] !== 8'h3C || hs_q[hs0+1] !== 8'hC3) begin
        n_fail++;
        $display("FAIL b2b_data: got %h %h want 3c c3", hs_q[hs0], hs_q[hs0+1]);
      end
    end
    n_checks++;
    if (ovr_cnt != ovr0 || bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_status: got ovr=%0d valid=%b want 0 0", ovr_cnt - ovr0, bus.rx_valid);
    end
  endtask

  task automatic test_overrun();
    int ovr0, hs0;
    ovr0 = ovr_cnt; hs0 = hs_q.size();
    bus.rx_ready = 1'b0;
    cs_low();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    cs_high();
    n_checks++;
    if (bus.rx_data !== 8'h11 || bus.rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_data: got data=%h valid=%b want 11 1", bus.rx_data, bus.rx_valid);
    end
    n_checks++;
    if (ovr_cnt != ovr0 + 1) begin
      n_fail++;
      $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - ovr0);
    end
    drain();
    n_checks++;
    if (hs_q.size() != hs0 + 1 || hs_q[hs_q.size()-1] !== 8'h11) begin
      n_fail++;
      $display("FAIL overrun_handshake: got count=%0d want 1 of 11", hs_q.size() - hs0);
    end
  endtask

  task automatic test_accept_same_cycle();
    int ovr0, hs0;
    ovr0 = ovr_cnt; hs0 = hs_q.size();
    bus.rx_ready = 1'b0;
    cs_low();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    cs_high();
    n_checks++;
    if (ovr_cnt != ovr0) begin
      n_fail++;
      $display("FAIL same_cycle_overrun: got %0d pulses want 0", ovr_cnt - ovr0);
    end
    n_checks++;
    if (bus.rx_data !== 8'h22 || bus.rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_data: got data=%h valid=%b want 22 1", bus.rx_data, bus.rx_valid);
    end
    n_checks++;
    if (hs_q.size() != hs0 + 1 || hs_q[hs_q.size()-1] !== 8'h11) begin
      n_fail++;
      $display("FAIL same_cycle_accept: got count=%0d want 1 of 11", hs_q.size() - hs0);
    end
    drain();
  endtask

  task automatic test_abort();
    logic [7:0] b;
    int fe0, hs0;
    b = 8'hB7; fe0 = fe_cnt; hs0 = hs_q.size();
    cs_low();
    for (int i = 7; i >= 3; i--) send_bit(b[i], 1'b0);
    cs_high();
    n_checks++;
    if (bus.rx_valid !== 1'b0 || hs_q.size() != hs0) begin
      n_fail++;
      $display("FAIL abort_no_word: got valid=%b handshakes=%0d want 0 0",
               bus.rx_valid, hs_q.size() - hs0);
    end
`ifdef SPI_RX_FRAME_ERR_EN
    n_checks++;
    if (fe_cnt != fe0 + 1) begin
      n_fail++;
      $display("FAIL abort_frame_err: got %0d pulses want 1", fe_cnt - fe0);
    end
`endif
    cs_low();
    cs_high();
    cs_low();
    send_byte(8'h5A, 1'b0);
    cs_high();
    n_checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_recover: got valid=%b data=%h want 1 5a", bus.rx_valid, bus.rx_data);
    end
`ifdef SPI_RX_FRAME_ERR_EN
    n_checks++;
    if (fe_cnt != fe0 + 1) begin
      n_fail++;
      $display("FAIL empty_abort_frame_err: got %0d pulses want 1", fe_cnt - fe0);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int hs0;
    b = 8'hE4;
    cs_low();
    send_byte(8'h81, 1'b0);
    for (int i = 7; i >= 5; i--) send_bit(b[i], 1'b0);
    n_checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h81) begin
      n_fail++;
      $display("FAIL pre_reset_word: got valid=%b data=%h want 1 81", bus.rx_valid, bus.rx_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00 || bus.busy !== 1'b0
        || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got valid=%b data=%h busy=%b ovr=%b want 0 00 0 0",
               bus.rx_valid, bus.rx_data, bus.busy, bus.overrun);
    end
    bus.sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hs0 = hs_q.size();
    bus.rx_ready = 1'b1;
    send_byte(8'hFF, 1'b0);
    cs_high();
    bus.rx_ready = 1'b0;
    n_checks++;
    if (bus.rx_valid !== 1'b0 || hs_q.size() != hs0) begin
      n_fail++;
      $display("FAIL reset_frame_ignored: got valid=%b handshakes=%0d want 0 0",
               bus.rx_valid, hs_q.size() - hs0);
    end
    cs_low();
    send_byte(8'h96, 1'b0);
    cs_high();
    n_checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h96) begin
      n_fail++;
      $display("FAIL reset_next_frame: got valid=%b data=%h want 1 96", bus.rx_valid, bus.rx_data);
    end
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ovr_cnt  = 0;
    fe_cnt   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_accept_same_cycle();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
